// File: rtl/spectrum_pkg.sv
// spectrum_pkg -- shared definitions for the spectrum frame scheduler.
//   Default bin geometry, vblank line and decay settings, the FSM state
//   enum, and a helper that extracts one bin from a packed spectrum bus.
package spectrum_pkg;

   localparam int              NUM_BINS_DEF     = 16;
   localparam int              BIN_W_DEF        = 16;
   localparam int              V_ACTIVE_DEF     = 480;
   localparam logic [15:0]     DECAY_STEP_DEF   = 16'h0040;
   localparam int              DECAY_FRAMES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Bin idx of a packed spectrum bus; bin i sits at [i*BIN_W +: BIN_W].
   function automatic logic [BIN_W_DEF-1:0] bin_slice(
      input logic [NUM_BINS_DEF*BIN_W_DEF-1:0] bus,
      input int                                idx
   );
      return bus[idx*BIN_W_DEF +: BIN_W_DEF];
   endfunction

endpackage

// File: rtl/spectrum_frame_ctrl_if.sv
// spectrum_frame_ctrl_if -- spectrum source handshake.
//   sound_signal : packed spectrum, bin i at [i*BIN_W +: BIN_W]
//   sound_valid  : source has a spectrum to hand over
//   sound_ready  : scheduler snapshot buffer is free
//   master = spectrum source, slave = spectrum_frame_ctrl.
interface spectrum_frame_ctrl_if
   import spectrum_pkg::*;
#(
   parameter int NUM_BINS = NUM_BINS_DEF,
   parameter int BIN_W    = BIN_W_DEF
);

   logic [NUM_BINS*BIN_W-1:0] sound_signal;
   logic                      sound_valid;
   logic                      sound_ready;

   modport master (output sound_signal, output sound_valid, input  sound_ready);
   modport slave  (input  sound_signal, input  sound_valid, output sound_ready);

endinterface

// File: rtl/spectrum_frame_ctrl_peak_hold_alu.sv
// peak_hold_alu -- combinational per-bin peak-hold step.
//   new_bin  : incoming bin value (0 when no new spectrum this frame)
//   held_bin : currently displayed value of the same bin
//   decay    : this frame applies one saturating decay step
//   disp_bin : next displayed value = max(new_bin, decayed held_bin)
// All comparisons are unsigned.
module peak_hold_alu
   import spectrum_pkg::*;
#(
   parameter int               BIN_W      = BIN_W_DEF,
   parameter logic [BIN_W-1:0] DECAY_STEP = BIN_W'(DECAY_STEP_DEF)
) (
   input  logic [BIN_W-1:0] new_bin,
   input  logic [BIN_W-1:0] held_bin,
   input  logic             decay,
   output logic [BIN_W-1:0] disp_bin
);

   // Floors at zero so quiet bins never wrap to full scale.
   function automatic logic [BIN_W-1:0] sat_dec(input logic [BIN_W-1:0] v);
      return (v > DECAY_STEP) ? v - DECAY_STEP : '0;
   endfunction

   function automatic logic [BIN_W-1:0] umax(input logic [BIN_W-1:0] a,
                                             input logic [BIN_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [BIN_W-1:0] held_dec;

   assign held_dec = decay ? sat_dec(held_bin) : held_bin;
   assign disp_bin = umax(new_bin, held_dec);

endmodule

// File: rtl/spectrum_frame_ctrl.sv
// spectrum_frame_ctrl -- frame-synchronous spectrum scheduler for graphics.
//   Buffers one spectrum snapshot from the source and commits it to the
//   display bin bank in a serial one-bin-per-cycle pass started at the
//   vblank event (hc==0 && vc==V_ACTIVE), so bars never tear mid-frame.
// Ports:
//   vga_clk, reset_n : pixel clock, asynchronous active-low reset
//   hc, vc           : VGA horizontal / vertical counters
//   snd (slave)      : sound_signal / sound_valid / sound_ready handshake
//   display_bins     : committed bins, same packing as sound_signal
//   current_peak     : max of display_bins after the last pass
//   frame_tick       : one-cycle pulse when a frame's work completes
//   busy             : pass in progress (UPDATE and DONE)
// Build option: define SPECTRUM_PEAK_HOLD_EN for peak-hold with periodic
//   decay and a pass every vblank; otherwise bins are copied straight from
//   the snapshot and a pass runs only when a snapshot is pending.
module spectrum_frame_ctrl
   import spectrum_pkg::*;
#(
   parameter int               NUM_BINS     = NUM_BINS_DEF,
   parameter int               BIN_W        = BIN_W_DEF,
`ifdef SPECTRUM_PEAK_HOLD_EN
   parameter logic [BIN_W-1:0] DECAY_STEP   = BIN_W'(DECAY_STEP_DEF),
   parameter int               DECAY_FRAMES = DECAY_FRAMES_DEF,
`endif
   parameter int               V_ACTIVE     = V_ACTIVE_DEF
) (
   input  logic                      vga_clk,
   input  logic                      reset_n,
   input  logic [9:0]                hc,
   input  logic [9:0]                vc,
   spectrum_frame_ctrl_if.slave      snd,
   output logic [NUM_BINS*BIN_W-1:0] display_bins,
   output logic [BIN_W-1:0]          current_peak,
   output logic                      frame_tick,
   output logic                      busy
);

   localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

   state_t           state, state_nx;
   logic [IDX_W-1:0] bin_idx;
   logic             use_new;
   logic             pend_valid;
   logic [BIN_W-1:0] pend [NUM_BINS];
   logic [BIN_W-1:0] disp [NUM_BINS];
   logic [BIN_W-1:0] runmax;

   logic             vblank_evt;
   logic             last_bin;
   logic             start_pass;
   logic             tick_nx;
   logic             capture;
   logic [BIN_W-1:0] new_bin;
   logic [BIN_W-1:0] disp_nx;

   function automatic logic [BIN_W-1:0] umax(input logic [BIN_W-1:0] a,
                                             input logic [BIN_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   assign vblank_evt = (hc == 10'd0) && (vc == 10'(V_ACTIVE));
   assign last_bin   = (bin_idx == IDX_W'(NUM_BINS-1));
   assign capture    = snd.sound_valid && !pend_valid;
   assign new_bin    = use_new ? pend[bin_idx] : '0;

   assign snd.sound_ready = ~pend_valid;

   for (genvar g = 0; g < NUM_BINS; g++) begin : g_out
      assign display_bins[g*BIN_W +: BIN_W] = disp[g];
   end

`ifdef SPECTRUM_PEAK_HOLD_EN
   localparam int FC_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

   logic [FC_W-1:0] frame_cnt;
   logic            decay_frame;

   assign decay_frame = (frame_cnt == FC_W'(DECAY_FRAMES-1));

   peak_hold_alu #(
      .BIN_W      (BIN_W),
      .DECAY_STEP (DECAY_STEP)
   ) u_alu (
      .new_bin  (new_bin),
      .held_bin (disp[bin_idx]),
      .decay    (decay_frame),
      .disp_bin (disp_nx)
   );

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
      end else if (state == ST_DONE) begin
         frame_cnt <= decay_frame ? '0 : frame_cnt + FC_W'(1);
      end
   end
`else
   assign disp_nx = new_bin;
`endif

   // FSM state register
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // FSM next state; a vblank event outside IDLE is ignored
   always_comb begin
      state_nx   = state;
      start_pass = 1'b0;
      tick_nx    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (vblank_evt) begin
`ifdef SPECTRUM_PEAK_HOLD_EN
               start_pass = 1'b1;
               state_nx   = ST_UPDATE;
`else
               // Nothing pending: skip the pass but still mark the frame.
               if (pend_valid) begin
                  start_pass = 1'b1;
                  state_nx   = ST_UPDATE;
               end else begin
                  tick_nx = 1'b1;
               end
`endif
            end
         end
         ST_UPDATE: begin
            if (last_bin) begin
               state_nx = ST_DONE;
               tick_nx  = 1'b1;
            end
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Snapshot data bank, written only on a handshake transfer
   always_ff @(posedge vga_clk) begin
      if (capture) begin
         for (int i = 0; i < NUM_BINS; i++) pend[i] <= bin_slice(snd.sound_signal, i);
      end
   end

   // Pass control, display bank and registered outputs
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         bin_idx      <= '0;
         use_new      <= 1'b0;
         pend_valid   <= 1'b0;
         runmax       <= '0;
         current_peak <= '0;
         frame_tick   <= 1'b0;
         busy         <= 1'b0;
         for (int i = 0; i < NUM_BINS; i++) disp[i] <= '0;
      end else begin
         frame_tick <= tick_nx;
         busy       <= (state_nx != ST_IDLE);

         // Snapshot is released only once its pass has fully committed.
         if (state == ST_DONE && use_new) pend_valid <= 1'b0;
         else if (capture)                pend_valid <= 1'b1;

         if (start_pass) begin
            bin_idx <= '0;
            use_new <= pend_valid;
            runmax  <= '0;
         end

         if (state == ST_UPDATE) begin
            disp[bin_idx] <= disp_nx;
            runmax        <= umax(runmax, disp_nx);
            bin_idx       <= bin_idx + IDX_W'(1);
         end

         if (state == ST_DONE) current_peak <= runmax;
      end
   end

endmodule
